// File: rtl/seqpu_core_p.sv
// seqpu_core_p: parametrised multi-cycle seqpu core.
// FETCH/EXEC/LOAD/ALU machine on an async SRAM bus with wait states and halt.
module seqpu_core_p #(
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              wren_n,
  output logic              oen_n,
  output logic [1:0]        state_o,
  output logic [1:0]        flags_o
);

  localparam int W = DATA_W;
  localparam logic [3:0]   WS  = 4'(WAIT_STATES);
  localparam logic [W-1:0] RPC = W'(RESET_PC);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    LOAD  = 2'd2,
    ALU   = 2'd3
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] pc, pc_n;
  logic [W-1:0] a, a_n;
  logic [W-1:0] b, b_n;
  logic [W-1:0] op, op_n;
  logic         z, z_n;
  logic         c, c_n;
  logic [3:0]   cnt, cnt_n;

  logic [1:0]   cls;
  logic [2:0]   fn;
  logic [1:0]   dst;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] r;
  logic [W-1:0] pc_inc;
  logic         is_store;
  logic         is_load;
  logic         idle;
  logic         mem_done;

  assign cls      = op[W-1:W-2];
  assign fn       = op[W-5:W-7];
  assign dst      = op[W-3:W-4];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign pc_inc   = pc + ONE;
  assign is_store = (cls == 2'b01) && !op[W-3];
  assign is_load  = (cls == 2'b01) && op[W-3];
  assign mem_done = (cnt == 4'd0);
  // A fetch counts as not yet started while the counter is still full.
  assign idle     = halt && (cnt == WS);

  always_comb begin
    r = '0;
    unique case (fn)
      3'b000: r = sum[W-1:0];
      3'b001: r = diff[W-1:0];
      3'b010: r = a | b;
      3'b011: r = a & b;
      3'b100: r = a ^ b;
      3'b101: r = b;
      3'b110: r = a;
      3'b111: r = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    a_n     = a;
    b_n     = b;
    op_n    = op;
    z_n     = z;
    c_n     = c;
    cnt_n   = cnt;
    unique case (state)
      FETCH: begin
        if (idle) begin
          cnt_n = cnt;
        end else if (!mem_done) begin
          cnt_n = cnt - 4'd1;
        end else begin
          op_n    = data_in;
          state_n = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          cls == 2'b00: begin
            b_n     = {2'b00, op[W-3:0]};
            state_n = ALU;
          end
          is_store: begin
            if (!mem_done) cnt_n = cnt - 4'd1;
            else state_n = ALU;
          end
          is_load: state_n = LOAD;
          cls == 2'b11: begin
            b_n     = {{(W-8){op[7]}}, op[7:0]};
            state_n = ALU;
          end
          cls == 2'b10: state_n = ALU;
        endcase
      end
      LOAD: begin
        if (!mem_done) begin
          cnt_n = cnt - 4'd1;
        end else begin
          b_n     = data_in;
          state_n = ALU;
        end
      end
      ALU: begin
        state_n = FETCH;
        if (!cls[1]) begin
          pc_n = pc_inc;
        end else begin
          unique case (dst)
            2'b00: begin a_n = r; pc_n = pc_inc; end
            2'b01: begin b_n = r; pc_n = pc_inc; end
            2'b10: pc_n = r;
            2'b11: pc_n = z ? r : pc_inc;
          endcase
          z_n = (r == '0);
          if (fn == 3'b000) c_n = sum[W];
          if (fn == 3'b001) c_n = diff[W];
        end
      end
    endcase
    if (state_n != state) cnt_n = WS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RPC;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      cnt   <= WS;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      a     <= a_n;
      b     <= b_n;
      op    <= op_n;
      z     <= z_n;
      c     <= c_n;
      cnt   <= cnt_n;
    end
  end

  // Strobes are gated by rst so an access aborts in the same cycle.
  always_comb begin
    address  = pc;
    data_out = a;
    wren_n   = 1'b1;
    oen_n    = 1'b1;
    unique case (state)
      FETCH: oen_n = idle;
      EXEC: begin
        if (is_store) begin
          address = b;
          wren_n  = 1'b0;
        end
      end
      LOAD: begin
        address = b;
        oen_n   = 1'b0;
      end
      ALU: oen_n = 1'b1;
    endcase
    if (rst) begin
      wren_n = 1'b1;
      oen_n  = 1'b1;
    end
  end

  assign state_o = state;
  assign flags_o = {c, z};

endmodule

// File: tb/tb_seqpu_core_p.sv
// tb_seqpu_core_p: random programs run against an instruction-level model;
// expected bus cycles are queued and a monitor compares them as they appear.
module tb_seqpu_core_p;

  localparam int W   = 16;
  localparam int WS  = 2;
  localparam int RPC = 'h10;
  localparam int AW  = 12;
  localparam int MD  = 1 << AW;

  localparam logic [1:0] K_F = 2'd0;
  localparam logic [1:0] K_L = 2'd1;
  localparam logic [1:0] K_S = 2'd2;
  localparam logic [1:0] K_X = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt = 1'b1;
  logic [W-1:0] data_in;
  logic [W-1:0] address;
  logic [W-1:0] data_out;
  logic         wren_n;
  logic         oen_n;
  logic [1:0]   state_o;
  logic [1:0]   flags_o;

  logic [W-1:0] mem [MD];
  logic [W-1:0] mm  [MD];
  logic         load_req = 1'b0;

  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [1:0]   flags;
  } ev_t;

  ev_t q[$];
  ev_t got;
  ev_t exp_e;
  int  errors = 0;
  int  checks = 0;
  bit  check_en = 1'b0;

  seqpu_core_p #(
    .DATA_W(W),
    .WAIT_STATES(WS),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .halt(halt),
    .data_in(data_in),
    .address(address),
    .data_out(data_out),
    .wren_n(wren_n),
    .oen_n(oen_n),
    .state_o(state_o),
    .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  assign data_in = mem[address[AW-1:0]];

  always @(posedge clk) begin
    if (load_req) mem <= mm;
    else if (!wren_n) mem[address[AW-1:0]] <= data_out;
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      checks++;
      if (!(wren_n | oen_n)) begin
        errors++;
        $display("FAIL strobe_excl wren_n=%b oen_n=%b required one high",
                 wren_n, oen_n);
      end
      if ((!oen_n || !wren_n) && q.size() != 0) begin
        got.kind  = !wren_n ? K_S :
                    (state_o == 2'd0) ? K_F :
                    (state_o == 2'd2) ? K_L : K_X;
        got.addr  = address;
        got.data  = !wren_n ? data_out : '0;
        got.flags = flags_o;
        exp_e = q.pop_front();
        checks++;
        if (got !== exp_e) begin
          errors++;
          $display("FAIL bus_event got k=%0d a=%h d=%h f=%b exp k=%0d a=%h d=%h f=%b",
                   got.kind, got.addr, got.data, got.flags,
                   exp_e.kind, exp_e.addr, exp_e.data, exp_e.flags);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_n(input logic [1:0] k, input logic [W-1:0] ad,
                        input logic [W-1:0] d, input logic [1:0] f);
    ev_t e;
    e.kind  = k;
    e.addr  = ad;
    e.data  = d;
    e.flags = f;
    repeat (WS + 1) q.push_back(e);
  endtask

  // Instruction-level reference: one loop iteration per instruction.
  task automatic model(input int n);
    int unsigned pc = RPC;
    int unsigned a = 0, b = 0, z = 0, c = 0;
    int unsigned ins, cls, fn, dst, r, t;
    int unsigned m = (1 << W) - 1;
    logic [1:0]  fl;
    for (int i = 0; i < n; i++) begin
      fl = {c[0], z[0]};
      push_n(K_F, W'(pc), '0, fl);
      ins = mm[pc % MD];
      cls = ins >> (W - 2);
      if (cls == 0) begin
        b  = ins & (m >> 2);
        pc = (pc + 1) & m;
      end else if (cls == 1) begin
        if (((ins >> (W - 3)) & 1) == 1) begin
          push_n(K_L, W'(b), '0, fl);
          b = mm[b % MD];
        end else begin
          push_n(K_S, W'(b), W'(a), fl);
          mm[b % MD] = W'(a);
        end
        pc = (pc + 1) & m;
      end else begin
        if (cls == 3) begin
          b = ins & 'hFF;
          if (b >= 'h80) b = b | (m & ~32'hFF);
        end
        fn  = (ins >> (W - 7)) & 7;
        dst = (ins >> (W - 4)) & 3;
        case (fn)
          0: begin t = a + b; r = t & m; c = (t >> W) & 1; end
          1: begin r = (a - b) & m; c = (a < b) ? 1 : 0; end
          2: r = a | b;
          3: r = a & b;
          4: r = a ^ b;
          5: r = b;
          6: r = a;
          default: r = 0;
        endcase
        case (dst)
          0: begin a = r; pc = (pc + 1) & m; end
          1: begin b = r; pc = (pc + 1) & m; end
          2: pc = r;
          default: pc = (z == 1) ? r : ((pc + 1) & m);
        endcase
        z = (r == 0) ? 1 : 0;
      end
    end
  endtask

  initial begin
    int cyc;
    logic [W-1:0] dir [6];
    dir[0] = 16'h3FFF;
    dir[1] = 16'h8A00;
    dir[2] = 16'hD080;
    dir[3] = 16'hC201;
    dir[4] = 16'h8E00;
    dir[5] = 16'hFA40;
    for (int ph = 0; ph < 6; ph++) begin
      rst  = 1'b1;
      halt = 1'b1;
      for (int i = 0; i < MD; i++) begin
        if (ph == 5) mm[i] = W'(16'h4000 | ($urandom & 16'h1FFF));
        else mm[i] = W'($urandom);
      end
      if (ph == 0) for (int i = 0; i < 6; i++) mm[RPC + i] = dir[i];
      @(posedge clk); #1 load_req = 1'b1;
      @(posedge clk); #1 load_req = 1'b0;
      q.delete();
      model(50);
      check_en = 1'b1;
      rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("halt_state", W'(state_o), '0);
        chk("halt_oen", W'(oen_n), W'(1));
        chk("halt_pc", address, W'(RPC));
        chk("reset_flags", W'(flags_o), '0);
      end
      cyc = 0;
      while (q.size() != 0 && cyc < 6000) begin
        @(posedge clk); #1 halt = ($urandom_range(0, 3) == 0);
        cyc++;
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d pending expected 0", q.size());
      end
      check_en = 1'b0;
      halt = 1'b0;
    end
    cyc = 0;
    while (wren_n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("store_seen", W'(wren_n), '0);
    #1 rst = 1'b1;
    #1;
    chk("rst_wren", W'(wren_n), W'(1));
    chk("rst_oen", W'(oen_n), W'(1));
    chk("rst_state", W'(state_o), '0);
    chk("rst_pc", address, W'(RPC));
    chk("rst_flags", W'(flags_o), '0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
